// File: rtl/prbs31_pkg.sv
// Shared constants, FSM encoding and predictor for the PRBS31 checker tile.
package prbs31_pkg;

    localparam int unsigned PRBS_LEN = 31;
    localparam int unsigned PRBS_TAP = 28;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    // Next bit of x^31 + x^28 + 1 given history with h[0] newest.
    function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] h);
        return h[PRBS_LEN-1] ^ h[PRBS_TAP-1];
    endfunction

endpackage

// File: rtl/prbs31_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module prbs31_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 receive checker with lock detection and error counting.
// Optional loss-of-lock resync is enabled by defining PRBS31_CHK_RESYNC_EN.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int unsigned VERIFY_LEN  = 64,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned WINDOW      = 1024,
    parameter int unsigned LOSS_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int unsigned CNT_MAX = (VERIFY_LEN > PRBS_LEN) ? VERIFY_LEN : PRBS_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    prbs_state_t         state_q, state_d;
    logic [PRBS_LEN-1:0] h_q, h_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pred_c;
    logic                err_c;
    logic                loss_c;

    assign pred_c = prbs_predict(h_q);
    assign err_c  = bit_valid && (state_q == LOCKED) && (bit_in != pred_c);
    assign state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            h_q       <= '0;
            cnt_q     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            cnt_q     <= cnt_d;
            locked    <= (state_d == LOCKED);
            err_pulse <= err_c;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        if (bit_valid) begin
            case (state_q)
                LOAD: begin
                    h_d = {h_q[PRBS_LEN-2:0], bit_in};
                    if (cnt_q == CNT_W'(PRBS_LEN - 1)) begin
                        state_d = VERIFY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                VERIFY: begin
                    h_d = {h_q[PRBS_LEN-2:0], bit_in};
                    if ((bit_in == pred_c) && (h_q != '0)) begin
                        if (cnt_q == CNT_W'(VERIFY_LEN - 1)) begin
                            state_d = LOCKED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so one channel error costs one count.
                    h_d = {h_q[PRBS_LEN-2:0], pred_c};
                    if (loss_c) begin
                        state_d = VERIFY;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    prbs31_sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_c),
        .clr   (clear),
        .count (err_count)
    );

`ifdef PRBS31_CHK_RESYNC_EN
    localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned LT_W  = $clog2(LOSS_THRESH + 1);

    logic [WIN_W-1:0] win_cnt_q;
    logic [LT_W-1:0]  win_err;
    logic             win_wrap_c;
    logic             win_clr_c;

    assign win_wrap_c = bit_valid && (state_q == LOCKED) && (win_cnt_q == WIN_W'(WINDOW - 1));
    assign loss_c     = err_c && (win_err == LT_W'(LOSS_THRESH - 1));
    assign win_clr_c  = clear || (state_q != LOCKED) || win_wrap_c || loss_c;

    // Valid-bit position within the current loss-of-lock window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
        end else if (clear || (state_q != LOCKED) || loss_c) begin
            win_cnt_q <= '0;
        end else if (bit_valid) begin
            win_cnt_q <= win_wrap_c ? '0 : win_cnt_q + WIN_W'(1);
        end
    end

    prbs31_sat_counter #(.W(LT_W)) u_win_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_c),
        .clr   (win_clr_c),
        .count (win_err)
    );
`else
    logic unused_cfg;

    assign loss_c     = 1'b0;
    assign unused_cfg = ^{32'(WINDOW), 32'(LOSS_THRESH)};
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: default build plus an ERR_W=4 instance on shared stimulus.
module tb_prbs31_checker;

    localparam logic [30:0] SEED = 31'h7FFF_FFFF;

    typedef struct packed {
        logic [1:0]  st;
        logic        lk;
        logic        pl;
        logic [15:0] c16;
        logic [1:0]  st4;
        logic        lk4;
        logic        pl4;
        logic [3:0]  c4;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        clear;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;
    logic [1:0]  state4;

    int          checks = 0;
    int          errors = 0;
    logic [30:0] g;
    obs_t        exp_q[$];

    always #5 clk = ~clk;

    prbs31_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state     (state)
    );

    prbs31_checker #(.ERR_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear     (clear),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_count (err_count4),
        .state     (state4)
    );

    function automatic obs_t mk(input logic [1:0] st, input logic pl, input int c16, input int c4);
        obs_t o;
        o.st  = st;
        o.lk  = (st == 2'd2);
        o.pl  = pl;
        o.c16 = 16'(c16);
        o.st4 = st;
        o.lk4 = (st == 2'd2);
        o.pl4 = pl;
        o.c4  = 4'(c4);
        return o;
    endfunction

    function automatic obs_t sample();
        return {state, locked, err_pulse, err_count, state4, locked4, err_pulse4, err_count4};
    endfunction

    // Expected state for a clean stream after i valid bits since reset.
    function automatic logic [1:0] clean_st(input int i);
        return (i < 31) ? 2'd0 : (i < 95) ? 2'd1 : 2'd2;
    endfunction

    function automatic int sat4(input int k);
        return (k > 15) ? 15 : k;
    endfunction

    task automatic gen(output logic b);
        b = g[30] ^ g[27];
        g = {g[29:0], b};
    endtask

    task automatic drive(input logic b, input logic v, input logic c);
        @(negedge clk);
        bit_in    = b;
        bit_valid = v;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bit_valid = 1'b0;
        clear     = 1'b0;
        bit_in    = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        g     = SEED;
    endtask

    task automatic test_reset();
        obs_t got, e;
        logic b;
        bit_valid = 1'b0;
        clear     = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(2'd0, 1'b0, 0, 0));
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, got, e);
            end
        end
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            gen(b);
            drive(b, 1'b1, 1'b0);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL reset_prelock locked=%b exp=1", locked);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || locked !== 1'b0 || state4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_async state=%0d locked=%b exp state=0 locked=0", state, locked);
        end
    endtask

    task automatic test_clean_lock();
        obs_t got, e;
        logic b;
        do_reset();
        for (int i = 1; i <= 10000; i++) begin
            gen(b);
            exp_q.push_back(mk(clean_st(i), 1'b0, 0, 0));
            drive(b, 1'b1, 1'b0);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL clean_lock bit=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_single_error(input bit random_valid);
        obs_t got, e;
        logic b, v;
        int   i, cyc, pulses;
        do_reset();
        i = 0;
        cyc = 0;
        pulses = 0;
        while (i < 700 && cyc < 5000) begin
            cyc++;
            v = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v) begin
                i++;
                gen(b);
                if (i == 500) b = ~b;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            exp_q.push_back(mk(clean_st(i), v && (i == 500), (i >= 500) ? 1 : 0, (i >= 500) ? 1 : 0));
            drive(b, v, 1'b0);
            got = sample();
            e   = exp_q.pop_front();
            if (got.pl) pulses++;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single_error rv=%0d bit=%0d got=%h exp=%h", random_valid, i, got, e);
            end
        end
        checks++;
        if (i != 700) begin
            errors++;
            $display("FAIL single_error_timeout valid_bits=%0d exp=700", i);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL single_error_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_all_zero();
        obs_t got, e;
        do_reset();
        for (int i = 1; i <= 2000; i++) begin
            exp_q.push_back(mk((i < 31) ? 2'd0 : 2'd1, 1'b0, 0, 0));
            drive(1'b0, 1'b1, 1'b0);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL all_zero bit=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_saturate_clear();
        obs_t got, e;
        logic b, er, c, pl;
        int   k;
        do_reset();
        k = 0;
        for (int i = 1; i <= 2400; i++) begin
            gen(b);
            er = (i >= 200) && (i % 100 == 0);
            c  = (i == 2200);
            if (er) b = ~b;
            pl = er;
            if (c) k = 0;
            else if (er) k++;
            exp_q.push_back(mk(clean_st(i), pl, k, sat4(k)));
            drive(b, 1'b1, c);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL saturate_clear bit=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_resync();
        obs_t       got, e;
        logic       b, er;
        logic [1:0] st;
        int         k;
        do_reset();
        k = 0;
        for (int i = 1; i <= 600; i++) begin
            gen(b);
            er = (i >= 200) && (i <= 350) && ((i - 200) % 10 == 0);
            if (er) begin
                b = ~b;
                k++;
            end
`ifdef PRBS31_CHK_RESYNC_EN
            st = (i < 350) ? clean_st(i) : (i < 414) ? 2'd1 : 2'd2;
`else
            st = clean_st(i);
`endif
            exp_q.push_back(mk(st, er, k, sat4(k)));
            drive(b, 1'b1, 1'b0);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL resync bit=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clear     = 1'b0;
        g         = SEED;
        test_reset();
        test_clean_lock();
        test_single_error(1'b0);
        test_single_error(1'b1);
        test_all_zero();
        test_saturate_clear();
        test_resync();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
